// File: rtl/geofence_poly.sv
// Point-in-convex-polygon engine: sorts NUM_VERT vertices clockwise around V0, then edge-tests the target.
// Optional feature macro: GEOFENCE_ONEDGE_EN enables the on_edge boundary report.
module geofence_poly #(
    parameter int COORD_W  = 10,
    parameter int NUM_VERT = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               valid,
    output logic               is_inside,
    output logic               on_edge
);
    localparam int IW = $clog2(NUM_VERT);
    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int CW = 2 * COORD_W + 3;
    localparam logic [IW-1:0] LAST_V = IW'(NUM_VERT - 1);
    localparam logic [IW-1:0] LAST_J = IW'(NUM_VERT - 2);
    localparam logic [IW-1:0] LAST_P = IW'(NUM_VERT - 3);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RECV  = 4'd1,
        S_VEC = 4'd2,
        S_MUL = 4'd3,
        S_SWP = 4'd4,
        E_VEC = 4'd5,
        E_MUL = 4'd6,
        E_CHK = 4'd7,
        DONE  = 4'd8
    } state_t;

    function automatic logic signed [DW-1:0] vec_diff(input logic [COORD_W-1:0] p,
                                                      input logic [COORD_W-1:0] q);
        return $signed({1'b0, p}) - $signed({1'b0, q});
    endfunction

    // Sign-extended products keep the full range, so the difference never overflows.
    function automatic logic signed [CW-1:0] cross_prod(input logic signed [DW-1:0] ux,
                                                        input logic signed [DW-1:0] uy,
                                                        input logic signed [DW-1:0] wx,
                                                        input logic signed [DW-1:0] wy);
        logic signed [PW-1:0] p1;
        logic signed [PW-1:0] p2;
        p1 = PW'(ux) * PW'(wy);
        p2 = PW'(wx) * PW'(uy);
        return CW'(p1) - CW'(p2);
    endfunction

    state_t                 state_r, next_state_s;
    logic [COORD_W-1:0]     tx_r, ty_r;
    logic [COORD_W-1:0]     vx_r [NUM_VERT];
    logic [COORD_W-1:0]     vy_r [NUM_VERT];
    logic [IW-1:0]          cnt_r, pass_r, edge_r;
    logic [IW-1:0]          jn_s, en_s;
    logic signed [DW-1:0]   ax_r, ay_r, bx_r, by_r;
    logic signed [CW-1:0]   c_r;
    logic                   c_neg_s;
    logic                   fail_r;
    logic                   in_ready_r, valid_r, is_inside_r;

    assign jn_s      = cnt_r + IW'(1);
    assign en_s      = (edge_r == LAST_V) ? {IW{1'b0}} : edge_r + IW'(1);
    assign c_neg_s   = c_r[CW-1];
    assign in_ready  = in_ready_r & ~reset;
    assign valid     = valid_r & ~reset;
    assign is_inside = is_inside_r & ~reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:  if (in_valid) next_state_s = RECV; else next_state_s = IDLE;
            RECV:  if (in_valid && cnt_r == LAST_V) next_state_s = S_VEC; else next_state_s = RECV;
            S_VEC: next_state_s = S_MUL;
            S_MUL: next_state_s = S_SWP;
            S_SWP: if (cnt_r == LAST_J && pass_r == LAST_P) next_state_s = E_VEC;
                   else next_state_s = S_VEC;
            E_VEC: next_state_s = E_MUL;
            E_MUL: next_state_s = E_CHK;
            E_CHK: if (edge_r == LAST_V) next_state_s = DONE; else next_state_s = E_VEC;
            DONE:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Vertex store, shared vector/cross datapath, fail flag and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_VERT; k++) begin
                vx_r[k] <= {COORD_W{1'b0}};
                vy_r[k] <= {COORD_W{1'b0}};
            end
            tx_r        <= {COORD_W{1'b0}};
            ty_r        <= {COORD_W{1'b0}};
            cnt_r       <= {IW{1'b0}};
            pass_r      <= {IW{1'b0}};
            edge_r      <= {IW{1'b0}};
            ax_r        <= {DW{1'b0}};
            ay_r        <= {DW{1'b0}};
            bx_r        <= {DW{1'b0}};
            by_r        <= {DW{1'b0}};
            c_r         <= {CW{1'b0}};
            fail_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            valid_r     <= 1'b0;
            is_inside_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE) || (next_state_s == RECV);
            valid_r     <= 1'b0;
            is_inside_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        tx_r   <= X;
                        ty_r   <= Y;
                        cnt_r  <= {IW{1'b0}};
                        fail_r <= 1'b0;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        vx_r[cnt_r] <= X;
                        vy_r[cnt_r] <= Y;
                        if (cnt_r == LAST_V) begin
                            cnt_r  <= IW'(1);
                            pass_r <= {IW{1'b0}};
                            edge_r <= {IW{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + IW'(1);
                        end
                    end
                end
                S_VEC: begin
                    ax_r <= vec_diff(vx_r[cnt_r], vx_r[0]);
                    ay_r <= vec_diff(vy_r[cnt_r], vy_r[0]);
                    bx_r <= vec_diff(vx_r[jn_s], vx_r[0]);
                    by_r <= vec_diff(vy_r[jn_s], vy_r[0]);
                end
                S_MUL, E_MUL: begin
                    c_r <= cross_prod(ax_r, ay_r, bx_r, by_r);
                end
                S_SWP: begin
                    // Non-negative cross means Vj+1 is not clockwise of Vj: swap.
                    if (!c_neg_s) begin
                        vx_r[cnt_r] <= vx_r[jn_s];
                        vy_r[cnt_r] <= vy_r[jn_s];
                        vx_r[jn_s]  <= vx_r[cnt_r];
                        vy_r[jn_s]  <= vy_r[cnt_r];
                    end
                    if (cnt_r == LAST_J) begin
                        cnt_r  <= IW'(1);
                        pass_r <= pass_r + IW'(1);
                    end else begin
                        cnt_r <= jn_s;
                    end
                end
                E_VEC: begin
                    ax_r <= vec_diff(tx_r, vx_r[edge_r]);
                    ay_r <= vec_diff(ty_r, vy_r[edge_r]);
                    bx_r <= vec_diff(vx_r[en_s], vx_r[edge_r]);
                    by_r <= vec_diff(vy_r[en_s], vy_r[edge_r]);
                end
                E_CHK: begin
                    if (c_neg_s) fail_r <= 1'b1;
                    if (edge_r == LAST_V) begin
                        valid_r     <= 1'b1;
                        is_inside_r <= !(fail_r || c_neg_s);
                    end else begin
                        edge_r <= edge_r + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GEOFENCE_ONEDGE_EN
    logic zero_r;
    logic on_edge_r;
    logic c_zero_s;

    assign c_zero_s = (c_r == {CW{1'b0}});
    assign on_edge  = on_edge_r & ~reset;

    // Zero-cross flag: an inside target with a collinear edge lies on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_r    <= 1'b0;
            on_edge_r <= 1'b0;
        end else begin
            on_edge_r <= 1'b0;
            if (state_r == IDLE && in_valid) begin
                zero_r <= 1'b0;
            end else if (state_r == E_CHK) begin
                if (c_zero_s) zero_r <= 1'b1;
                if (edge_r == LAST_V) begin
                    on_edge_r <= !(fail_r || c_neg_s) && (zero_r || c_zero_s);
                end
            end
        end
    end
`else
    assign on_edge = 1'b0;
`endif

endmodule

// File: tb/tb_geofence_poly.sv
// Randomized self-checking bench for geofence_poly (N=6 and N=3 instances) against an order-free hull model.
module tb_geofence_poly;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid6, in_valid3;
    logic [9:0] X, Y;
    logic       rdy6, v6, ins6, oe6;
    logic       rdy3, v3, ins3, oe3;
    logic       rdy_s, v_s, ins_s, oe_s;
    int         sel = 6;
    int         errors = 0;
    int         checks = 0;
    int         qual_err = 0;

    always #5 clk = ~clk;

    geofence_poly #(.COORD_W(10), .NUM_VERT(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .in_ready(rdy6),
        .X(X), .Y(Y), .valid(v6), .is_inside(ins6), .on_edge(oe6));

    geofence_poly #(.COORD_W(10), .NUM_VERT(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(rdy3),
        .X(X), .Y(Y), .valid(v3), .is_inside(ins3), .on_edge(oe3));

    assign rdy_s = (sel == 3) ? rdy3 : rdy6;
    assign v_s   = (sel == 3) ? v3   : v6;
    assign ins_s = (sel == 3) ? ins3 : ins6;
    assign oe_s  = (sel == 3) ? oe3  : oe6;

    // Result bits must stay low whenever valid is low.
    always @(negedge clk) begin
        if ((!v6 && (ins6 || oe6)) || (!v3 && (ins3 || oe3))) qual_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inside test from hull edges found by brute force over vertex pairs (no ordering needed).
    function automatic void ref_model(input int n, input int tx, input int ty,
                                      input int px[8], input int py[8],
                                      output bit ins, output bit oe);
        longint ex, ey, c, t;
        int pos, neg;
        bit zero;
        ins  = 1'b1;
        zero = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                pos = 0;
                neg = 0;
                ex = px[j] - px[i];
                ey = py[j] - py[i];
                for (int k = 0; k < n; k++) begin
                    if (k != i && k != j) begin
                        c = ex * (py[k] - py[i]) - ey * (px[k] - px[i]);
                        if (c > 0) pos++;
                        else if (c < 0) neg++;
                    end
                end
                if (pos == 0 || neg == 0) begin
                    t = ex * (ty - py[i]) - ey * (tx - px[i]);
                    if ((pos > 0 && t < 0) || (neg > 0 && t > 0)) ins = 1'b0;
                    if (t == 0) zero = 1'b1;
                end
            end
        end
`ifdef GEOFENCE_ONEDGE_EN
        oe = ins && zero;
`else
        oe = 1'b0;
`endif
    endfunction

    task automatic set_iv(input logic v);
        if (sel == 3) in_valid3 = v;
        else in_valid6 = v;
    endtask

    task automatic send_beat(input int x, input int y, input int max_gap, output int waited);
        logic acc;
        if (max_gap > 0) begin
            set_iv(1'b0);
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
        X = 10'(x);
        Y = 10'(y);
        set_iv(1'b1);
        waited = 0;
        do begin
            @(negedge clk);
            acc = rdy_s;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 200);
        if (!acc) check_eq("beat_timeout", 32'(acc), 32'd1);
        set_iv(1'b0);
    endtask

    task automatic run_frame(input int n, input int tx, input int ty,
                             input int px[8], input int py[8], input int max_gap,
                             input bit hold_next, input int ntx, input int nty,
                             input bit chk_lat, input bit chk_b2b, input string tag);
        int w, k;
        bit got, e_ins, e_oe;
        ref_model(n, tx, ty, px, py, e_ins, e_oe);
        send_beat(tx, ty, chk_b2b ? 0 : max_gap, w);
        if (chk_b2b) check_eq({tag, "_b2b_accept"}, w, 32'd1);
        for (int i = 0; i < n; i++) send_beat(px[i], py[i], max_gap, w);
        if (hold_next) begin
            X = 10'(ntx);
            Y = 10'(nty);
            set_iv(1'b1);
        end
        got = 1'b0;
        k = 0;
        while (!got && k < 400) begin
            @(negedge clk);
            k++;
            got = v_s;
        end
        check_eq({tag, "_valid_seen"}, 32'(got), 32'd1);
        if (got) begin
            if (chk_lat) check_eq({tag, "_latency"}, k, 3 * ((n - 2) * (n - 2) + n) + 1);
            check_eq({tag, "_inside"}, 32'(ins_s), 32'(e_ins));
            check_eq({tag, "_on_edge"}, 32'(oe_s), 32'(e_oe));
            check_eq({tag, "_rdy_done"}, 32'(rdy_s), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen_poly(output int px[8], output int py[8], output int tx, output int ty);
        int  ox[8], oy[8];
        int  r, m, m2, j, tmp;
        real a;
        r = $urandom_range(250, 500);
        for (int k = 0; k < 8; k++) begin
            ox[k] = 0;
            oy[k] = 0;
        end
        for (int k = 0; k < 6; k++) begin
            a = 6.283185307 * (k + 0.35 * ($urandom_range(0, 1000) / 1000.0)) / 6.0;
            ox[k] = $rtoi(511.0 + r * $cos(a) + 0.5);
            oy[k] = $rtoi(511.0 + r * $sin(a) + 0.5);
        end
        m  = $urandom_range(0, 5);
        m2 = (m + 1) % 6;
        case ($urandom_range(0, 3))
            0: begin tx = $urandom_range(0, 1023); ty = $urandom_range(0, 1023); end
            1: begin tx = $urandom_range(311, 711); ty = $urandom_range(311, 711); end
            2: begin tx = ox[m]; ty = oy[m]; end
            default: begin
                if ((ox[m] + ox[m2]) % 2 == 0 && (oy[m] + oy[m2]) % 2 == 0) begin
                    tx = (ox[m] + ox[m2]) / 2;
                    ty = (oy[m] + oy[m2]) / 2;
                end else begin
                    tx = ox[m];
                    ty = oy[m];
                end
            end
        endcase
        px = ox;
        py = oy;
        for (int k = 5; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = px[k]; px[k] = px[j]; px[j] = tmp;
            tmp = py[k]; py[k] = py[j]; py[j] = tmp;
        end
    endtask

    initial begin
        int hx[8], hy[8], trx[8], try_[8], px[8], py[8];
        int tx, ty, w, seen;
        hx  = '{200, 0, 200, 100, 300, 100, 0, 0};
        hy  = '{200, 100, 0, 200, 100, 0, 0, 0};
        trx = '{0, 1023, 0, 0, 0, 0, 0, 0};
        try_ = '{0, 0, 1023, 0, 0, 0, 0, 0};

        reset = 1'b1;
        in_valid6 = 1'b0;
        in_valid3 = 1'b0;
        X = 10'd0;
        Y = 10'd0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(v6), 32'd0);
        check_eq("rst_inside", 32'(ins6), 32'd0);
        check_eq("rst_on_edge", 32'(oe6), 32'd0);
        check_eq("rst_in_ready", 32'(rdy6), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_rdy6", 32'(rdy6), 32'd1);
        check_eq("idle_rdy3", 32'(rdy3), 32'd1);
        @(posedge clk);
        #1;

        sel = 6;
        run_frame(6, 150, 100, hx, hy, 0, 1'b0, 0, 0, 1'b1, 1'b0, "hex_in");
        run_frame(6, 350, 100, hx, hy, 0, 1'b0, 0, 0, 1'b1, 1'b0, "hex_out");
        run_frame(6, 250, 50, hx, hy, 0, 1'b0, 0, 0, 1'b1, 1'b0, "hex_edge");
        run_frame(6, 150, 100, hx, hy, 0, 1'b1, 250, 50, 1'b1, 1'b0, "b2b1");
        run_frame(6, 250, 50, hx, hy, 0, 1'b0, 0, 0, 1'b1, 1'b1, "b2b2");
        run_frame(6, 150, 100, hx, hy, 3, 1'b0, 0, 0, 1'b0, 1'b0, "gap_in");
        run_frame(6, 250, 50, hx, hy, 3, 1'b0, 0, 0, 1'b0, 1'b0, "gap_edge");

        sel = 3;
        run_frame(3, 1023, 1023, trx, try_, 0, 1'b0, 0, 0, 1'b1, 1'b0, "tri_far");
        run_frame(3, 1, 1, trx, try_, 0, 1'b0, 0, 0, 1'b1, 1'b0, "tri_near");
        run_frame(3, 511, 512, trx, try_, 2, 1'b0, 0, 0, 1'b0, 1'b0, "tri_hyp");

        // Reset 20 cycles after the last vertex of a frame.
        sel = 6;
        send_beat(150, 100, 0, w);
        for (int i = 0; i < 6; i++) send_beat(hx[i], hy[i], 0, w);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(v6), 32'd0);
        check_eq("mid_rst_rdy", 32'(rdy6), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rdy_back", 32'(rdy6), 32'd1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (v6) seen++;
        end
        check_eq("mid_rst_no_valid", seen, 32'd0);
        @(posedge clk);
        #1;
        run_frame(6, 150, 100, hx, hy, 0, 1'b0, 0, 0, 1'b1, 1'b0, "post_rst");

        for (int it = 0; it < 25; it++) begin
            gen_poly(px, py, tx, ty);
            run_frame(6, tx, ty, px, py, $urandom_range(0, 2), 1'b0, 0, 0, 1'b1, 1'b0, "rand");
        end

        check_eq("qualify", qual_err, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
